// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates tags in program order, accepts out-of-order CDB
// results, forwards them to operand lookups and retires entries in order.
module reorder_buffer #(
    parameter int ROB_WIDTH = 4,
    parameter int REG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dispatch_valid,
    input  logic [REG_WIDTH-1:0] dispatch_arch_num,
    output logic                 dispatch_ready,
    output logic [ROB_WIDTH-1:0] dispatch_tag,
    input  logic                 cdb_valid,
    input  logic [ROB_WIDTH-1:0] cdb_tag,
    input  logic [31:0]          cdb_data,
    input  logic [ROB_WIDTH-1:0] rd_tag0,
    input  logic [ROB_WIDTH-1:0] rd_tag1,
    output logic                 rd_valid0,
    output logic                 rd_valid1,
    output logic [31:0]          rd_data0,
    output logic [31:0]          rd_data1,
    output logic                 commit_valid,
    output logic [REG_WIDTH-1:0] commit_arch_num,
    output logic [ROB_WIDTH-1:0] commit_tag,
    output logic [31:0]          commit_data,
    input  logic                 flush
);
    localparam int DEPTH = 2 ** ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] FULL_COUNT = (ROB_WIDTH + 1)'(DEPTH);

    logic                 r_valid [DEPTH];
    logic [REG_WIDTH-1:0] r_arch  [DEPTH];
    logic [31:0]          r_data  [DEPTH];
    logic [ROB_WIDTH-1:0] r_head;
    logic [ROB_WIDTH-1:0] r_tail;
    logic [ROB_WIDTH:0]   r_count;

    logic w_accept;
    logic w_cdb_write;

    always_comb begin
        dispatch_ready  = (r_count != FULL_COUNT) && !flush;
        dispatch_tag    = r_tail;
        w_accept        = dispatch_valid && dispatch_ready;
        w_cdb_write     = cdb_valid && !flush;
        // Commit looks only at stored valid bits, so a CDB write to the head
        // retires one cycle later rather than combinationally.
        commit_valid    = (r_count != '0) && r_valid[r_head] && !flush;
        commit_arch_num = r_arch[r_head];
        commit_tag      = r_head;
        commit_data     = r_data[r_head];
    end

    always_comb begin
        if (cdb_valid && (cdb_tag == rd_tag0)) begin
            rd_valid0 = 1'b1;
            rd_data0  = cdb_data;
        end else begin
            rd_valid0 = r_valid[rd_tag0];
            rd_data0  = r_data[rd_tag0];
        end
        if (cdb_valid && (cdb_tag == rd_tag1)) begin
            rd_valid1 = 1'b1;
            rd_data1  = cdb_data;
        end else begin
            rd_valid1 = r_valid[rd_tag1];
            rd_data1  = r_data[rd_tag1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else begin
            // Allocation clears the slot's stale valid bit; a CDB write to
            // the same slot in the same cycle would be a protocol violation.
            if (w_accept) begin
                r_valid[r_tail] <= 1'b0;
                r_tail          <= r_tail + ROB_WIDTH'(1);
            end
            if (w_cdb_write) begin
                r_valid[cdb_tag] <= 1'b1;
            end
            if (commit_valid) begin
                r_head <= r_head + ROB_WIDTH'(1);
            end
            r_count <= r_count + {{ROB_WIDTH{1'b0}}, w_accept}
                               - {{ROB_WIDTH{1'b0}}, commit_valid};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_accept) begin
            r_arch[r_tail] <= dispatch_arch_num;
        end
        if (!reset && w_cdb_write) begin
            r_data[cdb_tag] <= cdb_data;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a per-cycle vector table plus
// hand-written fill, full-wrap, flush and mid-stream reset sequences.
module tb_reorder_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        dispatch_valid;
    logic [4:0]  dispatch_arch_num;
    logic        dispatch_ready;
    logic [3:0]  dispatch_tag;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [3:0]  rd_tag0, rd_tag1;
    logic        rd_valid0, rd_valid1;
    logic [31:0] rd_data0, rd_data1;
    logic        commit_valid;
    logic [4:0]  commit_arch_num;
    logic [3:0]  commit_tag;
    logic [31:0] commit_data;
    logic        flush;

    int errors = 0;
    int checks = 0;

    reorder_buffer #(.ROB_WIDTH(4), .REG_WIDTH(5)) dut (
        .clk(clk), .reset(reset),
        .dispatch_valid(dispatch_valid), .dispatch_arch_num(dispatch_arch_num),
        .dispatch_ready(dispatch_ready), .dispatch_tag(dispatch_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .rd_tag0(rd_tag0), .rd_tag1(rd_tag1),
        .rd_valid0(rd_valid0), .rd_valid1(rd_valid1),
        .rd_data0(rd_data0), .rd_data1(rd_data1),
        .commit_valid(commit_valid), .commit_arch_num(commit_arch_num),
        .commit_tag(commit_tag), .commit_data(commit_data),
        .flush(flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dv;
        logic [4:0]  darch;
        logic        cv;
        logic [3:0]  ctg;
        logic [31:0] cd;
        logic [3:0]  rt0;
        logic [3:0]  rt1;
        logic        e_dr;
        logic [3:0]  e_dt;
        logic        e_cv;
        logic [4:0]  e_ca;
        logic [3:0]  e_ct;
        logic [31:0] e_cd;
        logic        e_rv0;
        logic [31:0] e_rd0;
        logic        e_rv1;
        logic [31:0] e_rd1;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        reset = 1'b0; flush = 1'b0;
        dispatch_valid = 1'b0; dispatch_arch_num = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        rd_tag0 = '0; rd_tag1 = '0;
    endtask

    // Inputs are driven 1 time unit after the rising edge; outputs are sampled
    // on the falling edge.
    task automatic advance();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        advance();
    endtask

    task automatic chk_commit(input string nm, input logic [3:0] tag,
                              input logic [4:0] arch, input logic [31:0] data);
        chk({nm, ".commit_valid"}, 32'(commit_valid), 32'd1);
        chk({nm, ".commit_tag"}, 32'(commit_tag), 32'(tag));
        chk({nm, ".commit_arch"}, 32'(commit_arch_num), 32'(arch));
        chk({nm, ".commit_data"}, commit_data, data);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,        4'd0, 4'd5, 1'b1, 4'd0, 1'b0, 5'd0, 4'd0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
        vecs[1]  = '{1'b1, 5'd7, 1'b0, 4'd0, 32'h0,        4'd0, 4'd5, 1'b1, 4'd0, 1'b0, 5'd0, 4'd0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
        vecs[2]  = '{1'b1, 5'd8, 1'b0, 4'd0, 32'h0,        4'd0, 4'd5, 1'b1, 4'd1, 1'b0, 5'd0, 4'd0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
        vecs[3]  = '{1'b1, 5'd9, 1'b0, 4'd0, 32'h0,        4'd0, 4'd5, 1'b1, 4'd2, 1'b0, 5'd0, 4'd0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
        vecs[4]  = '{1'b0, 5'd0, 1'b1, 4'd2, 32'h22,       4'd2, 4'd1, 1'b1, 4'd3, 1'b0, 5'd0, 4'd0, 32'h0,        1'b1, 32'h22,       1'b0, 32'h0};
        vecs[5]  = '{1'b0, 5'd0, 1'b1, 4'd1, 32'h11,       4'd2, 4'd1, 1'b1, 4'd3, 1'b0, 5'd0, 4'd0, 32'h0,        1'b1, 32'h22,       1'b1, 32'h11};
        vecs[6]  = '{1'b0, 5'd0, 1'b1, 4'd0, 32'h00,       4'd0, 4'd3, 1'b1, 4'd3, 1'b0, 5'd0, 4'd0, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0};
        vecs[7]  = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,        4'd0, 4'd3, 1'b1, 4'd3, 1'b1, 5'd7, 4'd0, 32'h00,       1'b1, 32'h0,        1'b0, 32'h0};
        vecs[8]  = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,        4'd1, 4'd2, 1'b1, 4'd3, 1'b1, 5'd8, 4'd1, 32'h11,       1'b1, 32'h11,       1'b1, 32'h22};
        vecs[9]  = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,        4'd2, 4'd2, 1'b1, 4'd3, 1'b1, 5'd9, 4'd2, 32'h22,       1'b1, 32'h22,       1'b1, 32'h22};
        vecs[10] = '{1'b1, 5'd3, 1'b0, 4'd0, 32'h0,        4'd3, 4'd3, 1'b1, 4'd3, 1'b0, 5'd0, 4'd0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
        vecs[11] = '{1'b0, 5'd0, 1'b1, 4'd3, 32'hDEADBEEF, 4'd3, 4'd3, 1'b1, 4'd4, 1'b0, 5'd0, 4'd0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
        vecs[12] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,        4'd3, 4'd3, 1'b1, 4'd4, 1'b1, 5'd3, 4'd3, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
        vecs[13] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h0,        4'd5, 4'd6, 1'b1, 4'd4, 1'b0, 5'd0, 4'd0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};

        // Table: dispatch, out-of-order completion, in-order commit, forwarding
        do_reset();
        for (int i = 0; i < 14; i++) begin
            dispatch_valid = vecs[i].dv; dispatch_arch_num = vecs[i].darch;
            cdb_valid = vecs[i].cv; cdb_tag = vecs[i].ctg; cdb_data = vecs[i].cd;
            rd_tag0 = vecs[i].rt0; rd_tag1 = vecs[i].rt1;
            @(negedge clk);
            chk($sformatf("v%0d.dispatch_ready", i), 32'(dispatch_ready), 32'(vecs[i].e_dr));
            chk($sformatf("v%0d.dispatch_tag", i), 32'(dispatch_tag), 32'(vecs[i].e_dt));
            chk($sformatf("v%0d.commit_valid", i), 32'(commit_valid), 32'(vecs[i].e_cv));
            if (vecs[i].e_cv) begin
                chk($sformatf("v%0d.commit_arch", i), 32'(commit_arch_num), 32'(vecs[i].e_ca));
                chk($sformatf("v%0d.commit_tag", i), 32'(commit_tag), 32'(vecs[i].e_ct));
                chk($sformatf("v%0d.commit_data", i), commit_data, vecs[i].e_cd);
            end
            chk($sformatf("v%0d.rd_valid0", i), 32'(rd_valid0), 32'(vecs[i].e_rv0));
            if (vecs[i].e_rv0) chk($sformatf("v%0d.rd_data0", i), rd_data0, vecs[i].e_rd0);
            chk($sformatf("v%0d.rd_valid1", i), 32'(rd_valid1), 32'(vecs[i].e_rv1));
            if (vecs[i].e_rv1) chk($sformatf("v%0d.rd_data1", i), rd_data1, vecs[i].e_rd1);
            advance();
        end

        // Fill: 16 back-to-back dispatches, then full
        do_reset();
        for (int i = 0; i < 16; i++) begin
            dispatch_valid = 1'b1; dispatch_arch_num = 5'((i + 1) % 32);
            @(negedge clk);
            chk($sformatf("fill%0d.ready", i), 32'(dispatch_ready), 32'd1);
            chk($sformatf("fill%0d.tag", i), 32'(dispatch_tag), 32'(i));
            chk($sformatf("fill%0d.commit_valid", i), 32'(commit_valid), 32'd0);
            advance();
        end
        dispatch_valid = 1'b1; dispatch_arch_num = 5'd31;
        @(negedge clk);
        chk("full.ready", 32'(dispatch_ready), 32'd0);
        chk("full.tag_wrapped", 32'(dispatch_tag), 32'd0);
        chk("full.commit_valid", 32'(commit_valid), 32'd0);
        advance();

        // Full with commit: slot freed and reallocated after tail wrap
        dispatch_valid = 1'b1; dispatch_arch_num = 5'd20;
        cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_data = 32'hA0;
        @(negedge clk);
        chk("fc0.ready", 32'(dispatch_ready), 32'd0);
        chk("fc0.commit_valid", 32'(commit_valid), 32'd0);
        advance();
        dispatch_valid = 1'b1; dispatch_arch_num = 5'd20;
        @(negedge clk);
        chk_commit("fc1", 4'd0, 5'd1, 32'hA0);
        chk("fc1.ready", 32'(dispatch_ready), 32'd0);
        advance();
        dispatch_valid = 1'b1; dispatch_arch_num = 5'd20; rd_tag0 = 4'd0;
        @(negedge clk);
        chk("fc2.ready", 32'(dispatch_ready), 32'd1);
        chk("fc2.tag_reuse", 32'(dispatch_tag), 32'd0);
        chk("fc2.commit_valid", 32'(commit_valid), 32'd0);
        advance();
        rd_tag0 = 4'd0; cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_data = 32'hB1;
        @(negedge clk);
        chk("fc3.stale_cleared", 32'(rd_valid0), 32'd0);
        chk("fc3.ready", 32'(dispatch_ready), 32'd0);
        chk("fc3.tag", 32'(dispatch_tag), 32'd1);
        chk("fc3.commit_valid", 32'(commit_valid), 32'd0);
        advance();
        cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 32'hC2;
        @(negedge clk);
        chk_commit("fc4", 4'd1, 5'd2, 32'hB1);
        chk("fc4.ready", 32'(dispatch_ready), 32'd0);
        advance();
        dispatch_valid = 1'b1; dispatch_arch_num = 5'd21;
        @(negedge clk);
        chk_commit("fc5", 4'd2, 5'd3, 32'hC2);
        chk("fc5.ready", 32'(dispatch_ready), 32'd1);
        chk("fc5.tag", 32'(dispatch_tag), 32'd1);
        advance();
        @(negedge clk);
        chk("fc6.ready", 32'(dispatch_ready), 32'd1);
        chk("fc6.tag", 32'(dispatch_tag), 32'd2);
        chk("fc6.commit_valid", 32'(commit_valid), 32'd0);
        advance();

        // Flush: 5 live, head and tag1 complete, flush beats dispatch/CDB/commit
        do_reset();
        for (int i = 0; i < 5; i++) begin
            dispatch_valid = 1'b1; dispatch_arch_num = 5'(10 + i);
            advance();
        end
        cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_data = 32'h111;
        advance();
        cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_data = 32'h100;
        advance();
        @(negedge clk);
        chk_commit("preflush", 4'd0, 5'd10, 32'h100);
        flush = 1'b1; dispatch_valid = 1'b1; dispatch_arch_num = 5'd30;
        cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 32'h222;
        #1;
        chk("flush.commit_valid", 32'(commit_valid), 32'd0);
        chk("flush.ready", 32'(dispatch_ready), 32'd0);
        advance();
        rd_tag0 = 4'd0; rd_tag1 = 4'd2;
        @(negedge clk);
        chk("postflush.ready", 32'(dispatch_ready), 32'd1);
        chk("postflush.tag", 32'(dispatch_tag), 32'd0);
        chk("postflush.commit_valid", 32'(commit_valid), 32'd0);
        chk("postflush.rd_valid0", 32'(rd_valid0), 32'd0);
        chk("postflush.rd_valid1", 32'(rd_valid1), 32'd0);
        advance();

        // Reset mid-stream: 10 live entries, two complete, then one reset cycle
        do_reset();
        for (int i = 0; i < 10; i++) begin
            dispatch_valid = 1'b1; dispatch_arch_num = 5'(i);
            advance();
        end
        cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_data = 32'h55;
        advance();
        cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_data = 32'h5A;
        advance();
        reset = 1'b1; dispatch_valid = 1'b1; dispatch_arch_num = 5'd4;
        advance();
        rd_tag0 = 4'd0; rd_tag1 = 4'd5;
        @(negedge clk);
        chk("midreset.ready", 32'(dispatch_ready), 32'd1);
        chk("midreset.tag", 32'(dispatch_tag), 32'd0);
        chk("midreset.commit_valid", 32'(commit_valid), 32'd0);
        chk("midreset.rd_valid0", 32'(rd_valid0), 32'd0);
        chk("midreset.rd_valid1", 32'(rd_valid1), 32'd0);
        advance();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_WIDTH, default 4, tag width; depth DEPTH = 2**ROB_WIDTH entries.
REQ-002 SHALL have parameter REG_WIDTH, default 5, architectural register number width.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port dispatch_valid  input  1  request to allocate one entry.
REQ-006 SHALL have port dispatch_arch_num  input  REG_WIDTH  destination register of allocated entry.
REQ-007 SHALL have port dispatch_ready  output  1  allocation is accepted this cycle.
REQ-008 SHALL have port dispatch_tag  output  ROB_WIDTH  tag given to the entry allocated this cycle (current tail).
REQ-009 SHALL have ports cdb_valid, cdb_tag, cdb_data  input  1/ROB_WIDTH/32  common data bus result broadcast.
REQ-010 SHALL have ports rd_tag0, rd_tag1  input  ROB_WIDTH  operand lookup tags.
REQ-011 SHALL have ports rd_valid0, rd_valid1  output  1  looked-up entry holds its result.
REQ-012 SHALL have ports rd_data0, rd_data1  output  32  result of looked-up entry.
REQ-013 SHALL have ports commit_valid, commit_arch_num, commit_tag, commit_data  output  1/REG_WIDTH/ROB_WIDTH/32  in-order retirement.
REQ-014 SHALL have port flush  input  1  discard all entries (branch mispredict).

Function
REQ-015 SHALL hold per entry: valid (result written), arch_num, 32-bit data; plus head, tail pointers (ROB_WIDTH bits, wrap modulo DEPTH) and count (ROB_WIDTH+1 bits, 0..DEPTH).
REQ-016 dispatch_ready SHALL be 1 iff count != DEPTH and flush == 0; combinational.
REQ-017 On dispatch_valid && dispatch_ready: entry[tail] gets valid=0, arch_num=dispatch_arch_num; tail increments by 1 with wrap DEPTH-1 -> 0.
REQ-018 On cdb_valid (flush == 0): entry[cdb_tag] gets valid=1, data=cdb_data; CDB to a non-allocated tag is a protocol violation, behaviour unspecified.
REQ-019 commit_valid SHALL be 1 iff count != 0 && entry[head].valid && flush == 0; combinational; commit_arch_num/tag/data taken from entry[head]; no commit stall input.
REQ-020 On commit_valid: head increments with wrap; entry is freed.
REQ-021 count next = count + dispatch_accept - commit_valid; simultaneous dispatch and commit leaves count unchanged, including at count == DEPTH (no dispatch then, since ready=0) and count == 0 (no commit).
REQ-022 CDB write to head entry SHALL commit in the following cycle, not the same cycle (one-cycle write-to-commit latency).
REQ-023 Read ports: if cdb_valid && cdb_tag == rd_tagN, rd_validN=1 and rd_dataN=cdb_data (forwarding); else rd_validN=entry[rd_tagN].valid, rd_dataN=entry[rd_tagN].data.
REQ-024 flush SHALL have priority over dispatch, CDB and commit: next cycle head=tail=0, count=0, all entry valid bits 0; no commit and no allocation in the flush cycle.
REQ-025 Allocation into a freed slot SHALL clear its stale valid bit so a late lookup never reports stale data as ready.

Reset
REQ-026 On reset (priority over flush and all inputs): head=0, tail=0, count=0, all entry valid=0; entry arch_num/data need not be reset.
REQ-027 Outputs the cycle after reset: dispatch_ready=1, dispatch_tag=0, commit_valid=0, rd_valid0/1=0 absent CDB match.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight entries identically to flush.

Verification
REQ-029 Fill: 16 back-to-back dispatches (arch 1..16 mod 32), no CDB -> tags 0..15 issued, dispatch_ready=0 after 16th, commit_valid stays 0.
REQ-030 Out-of-order completion: dispatch tags 0,1,2; CDB tag2=0x22, tag1=0x11, tag0=0x00 on successive cycles -> commits tag0,1,2 in three consecutive cycles starting one cycle after tag0 write, data 0x00,0x11,0x22.
REQ-031 Full with simultaneous commit: count=16, head written -> commit fires; next cycle dispatch_ready=1 and new tag equals old head tag (wrap 15->0 checked).
REQ-032 Forwarding: rd_tag0=3 while cdb_valid, cdb_tag=3, cdb_data=0xDEADBEEF -> rd_valid0=1, rd_data0=0xDEADBEEF same cycle; next cycle from storage identical.
REQ-033 Flush: 5 entries live, 2 completed, flush with dispatch_valid and cdb_valid high -> no commit, no allocation; next cycle count=0, dispatch_tag=0, rd_valid0/1=0.
REQ-034 Reset mid-stream: 10 live entries, reset 1 cycle -> state equals post-reset values of REQ-027.
